// File: rtl/mem_wb_stage_pkg.sv
// Shared types and widths for the memory-access / MEM-WB stage.
package mem_wb_stage_pkg;

  localparam int unsigned RREG_W  = 32;  // Rreg_Bus width
  localparam int unsigned RADDR_W = 5;   // Rreg_AddrBus width
  localparam int unsigned CNT_W   = 8;   // BUSY-cycle counter width

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic               wite_reg;
    logic [RADDR_W-1:0] wite_reg_addr;
    logic [RREG_W-1:0]  alu0;
    logic               read_mem;
    logic [RREG_W-1:0]  read_mem_data;
  } wb_bundle_t;

endpackage

// File: rtl/mem_wb_stage_dmem_timer.sv
// BUSY-cycle counter; expired_o flags the last cycle allowed to wait for ack.
module dmem_timer
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with req/ack data-memory handshake, timeout abort and
// the MEM/WB pipeline register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_MEM,
  input  logic               wite_reg_MEM,
  input  logic [RADDR_W-1:0] wite_reg_addr_MEM,
  input  logic [RREG_W-1:0]  ALU0_MEM,
  input  logic               read_mem_MEM,
  input  logic               wite_mem_MEM,
  input  logic [RREG_W-1:0]  wite_mem_data_MEM,
  output logic               stall_MEM,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [RREG_W-1:0]  dmem_addr,
  output logic [RREG_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [RREG_W-1:0]  dmem_rdata,
  output logic               wite_reg_WB,
  output logic [RADDR_W-1:0] wite_reg_addr_WB,
  output logic [RREG_W-1:0]  ALU0_WB,
  output logic               read_mem_WB,
  output logic [RREG_W-1:0]  read_mem_data_WB,
  output logic               mem_err
);

  mem_state_e         state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [RREG_W-1:0]  addr_q, addr_d;
  logic [RREG_W-1:0]  wdata_q, wdata_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic               load_q, load_d;
  logic               wreg_q, wreg_d;
  wb_bundle_t         wb_q, wb_d;
  logic               err_q, err_d;

  logic mem_op, accept, expired;

  assign mem_op = valid_MEM & (read_mem_MEM | wite_mem_MEM);
  assign accept = (state_q == MEM_IDLE) & mem_op;

  dmem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    (accept),
    .en_i     ((state_q == MEM_BUSY) & ~dmem_ack),
    .expired_o(expired)
  );

  // Next-state, handshake and WB-bundle selection; ALU0 of a memory op is the
  // latched address, so addr_q doubles as the latched ALU0.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dest_d    = dest_q;
    load_d    = load_q;
    wreg_d    = wreg_q;
    wb_d      = wb_q;
    err_d     = err_q;
    stall_MEM = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (mem_op) begin
          stall_MEM        = 1'b1;
          state_d          = MEM_BUSY;
          req_d            = 1'b1;
          we_d             = wite_mem_MEM;
          addr_d           = ALU0_MEM;
          wdata_d          = wite_mem_data_MEM;
          dest_d           = wite_reg_addr_MEM;
          load_d           = read_mem_MEM & ~wite_mem_MEM;
          wreg_d           = wite_reg_MEM & ~wite_mem_MEM;
          wb_d.wite_reg    = 1'b0;
          wb_d.read_mem    = 1'b0;
        end else if (valid_MEM) begin
          wb_d.wite_reg      = wite_reg_MEM;
          wb_d.wite_reg_addr = wite_reg_addr_MEM;
          wb_d.alu0          = ALU0_MEM;
          wb_d.read_mem      = 1'b0;
          wb_d.read_mem_data = '0;
        end else begin
          wb_d.wite_reg = 1'b0;
          wb_d.read_mem = 1'b0;
        end
      end
      MEM_BUSY: begin
        if (dmem_ack) begin
          state_d            = MEM_IDLE;
          req_d              = 1'b0;
          wb_d.wite_reg      = wreg_q;
          wb_d.wite_reg_addr = dest_q;
          wb_d.alu0          = addr_q;
          wb_d.read_mem      = load_q;
          wb_d.read_mem_data = load_q ? dmem_rdata : '0;
        end else if (expired) begin
          state_d       = MEM_IDLE;
          req_d         = 1'b0;
          err_d         = 1'b1;
          wb_d.wite_reg = 1'b0;
          wb_d.read_mem = 1'b0;
        end else begin
          stall_MEM     = 1'b1;
          wb_d.wite_reg = 1'b0;
          wb_d.read_mem = 1'b0;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // State, latched access fields and MEM/WB register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MEM_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dest_q  <= '0;
      load_q  <= 1'b0;
      wreg_q  <= 1'b0;
      wb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dest_q  <= dest_d;
      load_q  <= load_d;
      wreg_q  <= wreg_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign wite_reg_WB      = wb_q.wite_reg;
  assign wite_reg_addr_WB = wb_q.wite_reg_addr;
  assign ALU0_WB          = wb_q.alu0;
  assign read_mem_WB      = wb_q.read_mem;
  assign read_mem_data_WB = wb_q.read_mem_data;
  assign mem_err          = err_q;

endmodule
